// File: rtl/ps2_scan_decoder.sv
// PS/2 set-2 scan byte decoder: make/break/typematic events plus a held-key slot table.
// Define PS2_EXT_KEY_EN to compile in E0 extended-key prefix handling.
module ps2_scan_decoder #(
  parameter int unsigned SLOTS = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         byte_valid,
  input  logic [7:0]                   byte_data,
  output logic                         byte_ready,
  output logic                         evt_valid,
  output logic                         evt_make,
  output logic                         evt_rpt,
  output logic                         evt_ext,
  output logic [7:0]                   evt_code,
  output logic [7:0]                   last_code,
  output logic [$clog2(SLOTS+1)-1:0]   held_cnt,
  output logic [CNT_W-1:0]             press_cnt,
  output logic                         overflow
);

  localparam int unsigned HW = $clog2(SLOTS + 1);
  localparam int unsigned IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

`ifdef PS2_EXT_KEY_EN
  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;
`else
  typedef enum logic [0:0] {IDLE, BRK} state_t;
`endif

  state_t state_q, state_d;

  logic [SLOTS-1:0] slot_vld;
  logic [8:0]       slot_key [SLOTS];

  logic          fire, is_make, is_ext;
  logic [8:0]    key;
  logic          hit, free;
  logic [IW-1:0] hit_idx, free_idx;

  assign byte_ready = rst_n;
  assign key        = {is_ext, byte_data};

  always_comb begin
    state_d = state_q;
    fire    = 1'b0;
    is_make = 1'b0;
    is_ext  = 1'b0;
    if (byte_valid && byte_ready) begin
      case (state_q)
        IDLE: begin
          if (byte_data == 8'hE0) begin
`ifdef PS2_EXT_KEY_EN
            state_d = EXT;
`endif
          end else if (byte_data == 8'hF0) begin
            state_d = BRK;
          end else begin
            fire    = 1'b1;
            is_make = 1'b1;
          end
        end
        BRK: begin
          fire    = 1'b1;
          state_d = IDLE;
        end
`ifdef PS2_EXT_KEY_EN
        EXT: begin
          // a repeated E0 is just a redundant prefix
          if (byte_data == 8'hF0) begin
            state_d = EXT_BRK;
          end else if (byte_data != 8'hE0) begin
            fire    = 1'b1;
            is_make = 1'b1;
            is_ext  = 1'b1;
            state_d = IDLE;
          end
        end
        EXT_BRK: begin
          fire    = 1'b1;
          is_ext  = 1'b1;
          state_d = IDLE;
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (slot_vld[i] && (slot_key[i] == key) && !hit) begin
        hit     = 1'b1;
        hit_idx = i[IW-1:0];
      end
      if (!slot_vld[i] && !free) begin
        free     = 1'b1;
        free_idx = i[IW-1:0];
      end
    end
  end

  always_comb begin
    held_cnt = '0;
    for (int unsigned i = 0; i < SLOTS; i++)
      held_cnt = held_cnt + HW'(slot_vld[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      slot_vld  <= '0;
      for (int unsigned i = 0; i < SLOTS; i++) slot_key[i] <= '0;
      evt_valid <= 1'b0;
      evt_make  <= 1'b0;
      evt_rpt   <= 1'b0;
      evt_ext   <= 1'b0;
      evt_code  <= '0;
      last_code <= '0;
      press_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      state_q   <= state_d;
      evt_valid <= fire;
      if (fire) begin
        evt_make <= is_make;
        evt_rpt  <= is_make && hit;
        evt_ext  <= is_ext;
        evt_code <= byte_data;
        if (is_make && !hit) begin
          press_cnt <= press_cnt + 1'b1;
          last_code <= byte_data;
          if (free) begin
            slot_vld[free_idx] <= 1'b1;
            slot_key[free_idx] <= key;
          end else begin
            overflow <= 1'b1;
          end
        end
        if (!is_make && hit) slot_vld[hit_idx] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed bench for ps2_scan_decoder (SLOTS=4, CNT_W=4); extended-key cases follow PS2_EXT_KEY_EN.
module tb_ps2_scan_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = '0;
  logic       byte_ready, evt_valid, evt_make, evt_rpt, evt_ext, overflow;
  logic [7:0] evt_code, last_code;
  logic [2:0] held_cnt;
  logic [3:0] press_cnt;

  int errors = 0;
  int checks = 0;

  ps2_scan_decoder #(.SLOTS(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .evt_valid(evt_valid), .evt_make(evt_make),
    .evt_rpt(evt_rpt), .evt_ext(evt_ext), .evt_code(evt_code),
    .last_code(last_code), .held_cnt(held_cnt), .press_cnt(press_cnt),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic ev(input string tag, input logic mk, input logic rpt,
                    input logic ext, input logic [7:0] code);
    chk({tag, ".valid"}, evt_valid, 1);
    chk({tag, ".make"},  evt_make,  mk);
    chk({tag, ".rpt"},   evt_rpt,   rpt);
    chk({tag, ".ext"},   evt_ext,   ext);
    chk({tag, ".code"},  evt_code,  code);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst.ready",    byte_ready, 0);
    chk("rst.evt",      evt_valid,  0);
    chk("rst.held",     held_cnt,   0);
    chk("rst.press",    press_cnt,  0);
    chk("rst.overflow", overflow,   0);
    chk("rst.last",     last_code,  0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] c;
    do_reset();
    chk("ready", byte_ready, 1);
    chk("rst.code", evt_code, 0);

    // single make then break
    send(8'h1C); ev("mk1c", 1, 0, 0, 8'h1C);
    chk("mk1c.press", press_cnt, 1); chk("mk1c.held", held_cnt, 1); chk("mk1c.last", last_code, 8'h1C);
    send(8'hF0); chk("f0.noevt", evt_valid, 0);
    send(8'h1C); ev("brk1c", 0, 0, 0, 8'h1C); chk("brk1c.held", held_cnt, 0);
    @(posedge clk); #1; chk("pulse1", evt_valid, 0);

    // typematic repeat
    do_reset();
    send(8'h1C); ev("rp0", 1, 0, 0, 8'h1C);
    send(8'h1C); ev("rp1", 1, 1, 0, 8'h1C);
    send(8'h1C); ev("rp2", 1, 1, 0, 8'h1C);
    send(8'hF0); send(8'h1C); ev("rpbrk", 0, 0, 0, 8'h1C);
    chk("rp.press", press_cnt, 1); chk("rp.held", held_cnt, 0);

    // slot table full / overflow
    do_reset();
    send(8'h1C); send(8'h1B); send(8'h23); send(8'h2B);
    chk("full.held", held_cnt, 4); chk("full.ovf0", overflow, 0);
    send(8'h34); ev("ovf", 1, 0, 0, 8'h34);
    chk("ovf.flag", overflow, 1); chk("ovf.held", held_cnt, 4);
    chk("ovf.press", press_cnt, 5); chk("ovf.last", last_code, 8'h34);
    send(8'hF0); send(8'h1B); ev("free1b", 0, 0, 0, 8'h1B); chk("free.held", held_cnt, 3);
    send(8'h33); ev("mk33", 1, 0, 0, 8'h33);
    chk("mk33.held", held_cnt, 4); chk("mk33.press", press_cnt, 6); chk("mk33.last", last_code, 8'h33);
    send(8'h33); ev("rp33", 1, 1, 0, 8'h33); chk("rp33.press", press_cnt, 6);
    send(8'h34); ev("mk34again", 1, 0, 0, 8'h34); chk("mk34.press", press_cnt, 7);
    send(8'hF0); send(8'h34); ev("brk34", 0, 0, 0, 8'h34); chk("brk34.held", held_cnt, 4);
    chk("ovf.sticky", overflow, 1);
    send(8'hF0); send(8'hE0); ev("brkE0", 0, 0, 0, 8'hE0);

    // press counter wrap at 4 bits
    do_reset();
    for (int i = 0; i < 16; i++) begin
      c = 8'h10 + 8'(i);
      send(c); send(8'hF0); send(c);
      if (i == 14) chk("wrap.15", press_cnt, 15);
    end
    chk("wrap.0", press_cnt, 0); chk("wrap.held", held_cnt, 0);

    // reset mid-sequence
    send(8'hF0);
    do_reset();
    send(8'h1C); ev("postrst", 1, 0, 0, 8'h1C); chk("postrst.held", held_cnt, 1);

    do_reset();
`ifdef PS2_EXT_KEY_EN
    send(8'hE0); chk("e0.noevt", evt_valid, 0);
    send(8'h75); ev("xmk75", 1, 0, 1, 8'h75); chk("xmk.held", held_cnt, 1);
    send(8'h75); ev("mk75", 1, 0, 0, 8'h75); chk("mk75.held", held_cnt, 2);
    send(8'hE0); send(8'hF0); send(8'h75); ev("xbrk75", 0, 0, 1, 8'h75); chk("xbrk.held", held_cnt, 1);
    send(8'hF0); send(8'h75); ev("brk75", 0, 0, 0, 8'h75); chk("brk75.held", held_cnt, 0);
    send(8'hE0); send(8'hE0); chk("e0e0.noevt", evt_valid, 0);
    send(8'h6B); ev("xmk6b", 1, 0, 1, 8'h6B);
    send(8'hE0); send(8'hF0); send(8'hE0); ev("xbrkE0", 0, 0, 1, 8'hE0);
`else
    send(8'hE0); chk("e0.noevt", evt_valid, 0);
    send(8'h75); ev("mk75", 1, 0, 0, 8'h75); chk("mk75.held", held_cnt, 1);
    send(8'hE0); send(8'hF0); send(8'h75); ev("brk75", 0, 0, 0, 8'h75); chk("brk75.held", held_cnt, 0);
    chk("noext.press", press_cnt, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
